// File: rtl/battleship_pkg.sv
// Shared Battleship constants, game-flow state encoding and board-coordinate helpers
// used by the turn scheduler, who_wins and the display logic.
package battleship_pkg;
   localparam int GRID_N     = 6;
   localparam int CELLS      = GRID_N * GRID_N;
   localparam int CELL_IDX_W = $clog2(CELLS);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_TURN    = 3'd1,
      ST_RESOLVE = 3'd2,
      ST_CHECK   = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   function automatic logic [CELL_IDX_W-1:0] cell_idx(input logic [2:0] row, input logic [2:0] col);
      return CELL_IDX_W'(int'(row) * GRID_N + int'(col));
   endfunction

   function automatic logic in_range(input logic [2:0] row, input logic [2:0] col);
      return (int'(row) < GRID_N) && (int'(col) < GRID_N);
   endfunction
endpackage

// File: rtl/turn_timer.sv
// Per-turn idle timer: reloads to TURN_TIMEOUT, counts down while enabled and
// flags the cycle on which the count reaches zero.
module turn_timer #(
   parameter int TURN_TIMEOUT = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int CW = $clog2(TURN_TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: a reload wins over the countdown, and the count parks at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CW'(TURN_TIMEOUT);
      end else if (en_i && (cnt_q != {CW{1'b0}})) begin
         cnt_d = cnt_q - CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = en_i && (cnt_q == CW'(1));
endmodule

// File: rtl/turn_scheduler.sv
// Two-player Battleship game-flow controller: loads boards, alternates turns,
// resolves one shot per turn and ends the game on the who_wins verdict.
module turn_scheduler #(
   parameter int GRID_N       = 6,
   parameter int CELLS        = 36,
   parameter int TURN_TIMEOUT = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CELLS-1:0] p1ships_init,
   input  logic [CELLS-1:0] p2ships_init,
   input  logic             shot_valid,
   input  logic [2:0]       shot_row,
   input  logic [2:0]       shot_col,
   output logic             shot_ready,
   input  logic             p1wins,
   input  logic             p2wins,
   output logic             taking_turns,
   output logic             turn,
   output logic [CELLS-1:0] p1ships,
   output logic [CELLS-1:0] p2ships,
   output logic             hit,
   output logic             miss,
   output logic             reject,
   output logic             timeout,
   output logic             game_over
);
   import battleship_pkg::*;

   localparam int IDX_W = $clog2(GRID_N * GRID_N);

   state_e           state_q, state_d;
   logic             turn_q, turn_d;
   logic [CELLS-1:0] p1_q, p1_d, p2_q, p2_d;
   logic [CELLS-1:0] fired1_q, fired1_d, fired2_q, fired2_d;
   logic             hit_q, hit_d, miss_q, miss_d, reject_q, reject_d, timeout_q, timeout_d;
   logic             ready_q, ready_d, taking_q, taking_d, over_q, over_d;
   logic [IDX_W-1:0] idx_s;
   logic             accept_s, fired_s, legal_s, expired_s, load_s, en_s;

   assign idx_s    = cell_idx(shot_row, shot_col);
   assign accept_s = shot_valid && ready_q;
   assign fired_s  = in_range(shot_row, shot_col) ? (turn_q ? fired2_q[idx_s] : fired1_q[idx_s]) : 1'b0;
   assign legal_s  = in_range(shot_row, shot_col) && !fired_s;

   // The shot is resolved on its accepting edge, so hit/miss and the board update are
   // visible during RESOLVE, which gives who_wins a cycle to register the new board.
   always_comb begin
      state_d   = state_q;
      turn_d    = turn_q;
      p1_d      = p1_q;
      p2_d      = p2_q;
      fired1_d  = fired1_q;
      fired2_d  = fired2_q;
      hit_d     = 1'b0;
      miss_d    = 1'b0;
      reject_d  = 1'b0;
      timeout_d = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               p1_d     = p1ships_init;
               p2_d     = p2ships_init;
               fired1_d = {CELLS{1'b0}};
               fired2_d = {CELLS{1'b0}};
               turn_d   = 1'b0;
               state_d  = ST_TURN;
            end else begin
               state_d = state_q;
            end
         end
         ST_TURN: begin
            if (accept_s && !legal_s) begin
               reject_d = 1'b1;
            end else if (accept_s) begin
               state_d = ST_RESOLVE;
               if (turn_q) begin
                  fired2_d[idx_s] = 1'b1;
                  if (p1_q[idx_s]) begin
                     p1_d[idx_s] = 1'b0;
                     hit_d       = 1'b1;
                  end else begin
                     miss_d = 1'b1;
                  end
               end else begin
                  fired1_d[idx_s] = 1'b1;
                  if (p2_q[idx_s]) begin
                     p2_d[idx_s] = 1'b0;
                     hit_d       = 1'b1;
                  end else begin
                     miss_d = 1'b1;
                  end
               end
            end else if (expired_s) begin
               timeout_d = 1'b1;
               state_d   = ST_CHECK;
            end else begin
               state_d = state_q;
            end
         end
         ST_RESOLVE: state_d = ST_CHECK;
         ST_CHECK: begin
            if (p1wins || p2wins) begin
               state_d = ST_DONE;
            end else begin
               turn_d  = ~turn_q;
               state_d = ST_TURN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      ready_d  = (state_d == ST_TURN);
      taking_d = (state_d == ST_TURN) || (state_d == ST_RESOLVE) || (state_d == ST_CHECK);
      over_d   = (state_d == ST_DONE);
   end

   // Restart the idle timer on every TURN entry and after each rejected shot.
   assign load_s = ((state_d == ST_TURN) && (state_q != ST_TURN)) || reject_d;
   assign en_s   = (state_q == ST_TURN);

   turn_timer #(.TURN_TIMEOUT(TURN_TIMEOUT)) u_timer (
      .clk       (clk),
      .rst_n     (reset),
      .load_i    (load_s),
      .en_i      (en_s),
      .expired_o (expired_s)
   );

   // State, boards, fired masks and all registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         turn_q    <= 1'b0;
         p1_q      <= {CELLS{1'b0}};
         p2_q      <= {CELLS{1'b0}};
         fired1_q  <= {CELLS{1'b0}};
         fired2_q  <= {CELLS{1'b0}};
         hit_q     <= 1'b0;
         miss_q    <= 1'b0;
         reject_q  <= 1'b0;
         timeout_q <= 1'b0;
         ready_q   <= 1'b0;
         taking_q  <= 1'b0;
         over_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         turn_q    <= turn_d;
         p1_q      <= p1_d;
         p2_q      <= p2_d;
         fired1_q  <= fired1_d;
         fired2_q  <= fired2_d;
         hit_q     <= hit_d;
         miss_q    <= miss_d;
         reject_q  <= reject_d;
         timeout_q <= timeout_d;
         ready_q   <= ready_d;
         taking_q  <= taking_d;
         over_q    <= over_d;
      end
   end

   assign shot_ready   = ready_q;
   assign taking_turns = taking_q;
   assign turn         = turn_q;
   assign p1ships      = p1_q;
   assign p2ships      = p2_q;
   assign hit          = hit_q;
   assign miss         = miss_q;
   assign reject       = reject_q;
   assign timeout      = timeout_q;
   assign game_over    = over_q;
endmodule

// File: tb/tb_turn_scheduler.sv
// Randomized self-checking bench for turn_scheduler against a transaction-level
// game model; who_wins is modelled as a registered "opponent fleet empty" flag.
module tb_turn_scheduler;
   localparam int T = 8;

   logic        clk = 1'b0;
   logic        reset, start, shot_valid, p1wins, p2wins;
   logic [35:0] p1ships_init, p2ships_init;
   logic [2:0]  shot_row, shot_col;
   logic        shot_ready, taking_turns, turn, hit, miss, reject, timeout, game_over;
   logic [35:0] p1ships, p2ships;

   turn_scheduler #(.GRID_N(6), .CELLS(36), .TURN_TIMEOUT(T)) dut (
      .clk(clk), .reset(reset), .start(start),
      .p1ships_init(p1ships_init), .p2ships_init(p2ships_init),
      .shot_valid(shot_valid), .shot_row(shot_row), .shot_col(shot_col),
      .shot_ready(shot_ready), .p1wins(p1wins), .p2wins(p2wins),
      .taking_turns(taking_turns), .turn(turn), .p1ships(p1ships), .p2ships(p2ships),
      .hit(hit), .miss(miss), .reject(reject), .timeout(timeout), .game_over(game_over)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p1wins <= 1'b0;
         p2wins <= 1'b0;
      end else begin
         p1wins <= taking_turns && (p2ships == 36'd0);
         p2wins <= taking_turns && (p1ships == 36'd0);
      end
   end

   // Game model: fleets and shot history per player, whose turn, and cycles spent idle in the turn.
   bit m_ship[2][36];
   bit m_fired[2][36];
   int m_turn;
   bit m_active;
   bit m_over;
   int age;
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [35:0] board(input int p);
      logic [35:0] v;
      v = 36'd0;
      for (int i = 0; i < 36; i++) v[i] = m_ship[p][i];
      return v;
   endfunction

   function automatic int afloat(input int p);
      int n;
      n = 0;
      for (int i = 0; i < 36; i++) n += int'(m_ship[p][i]);
      return n;
   endfunction

   function automatic logic [35:0] rand_board();
      logic [63:0] a, b, c;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      c = {$urandom, $urandom};
      a = a & b & c;
      if ($urandom_range(0, 11) == 0) a = 64'd0;
      return a[35:0];
   endfunction

   task automatic check_state(input string tag);
      check_eq({tag, ".turn"}, 64'(turn), 64'(m_turn));
      check_eq({tag, ".p1ships"}, 64'(p1ships), 64'(board(0)));
      check_eq({tag, ".p2ships"}, 64'(p2ships), 64'(board(1)));
      check_eq({tag, ".game_over"}, 64'(game_over), 64'(m_over));
      check_eq({tag, ".taking"}, 64'(taking_turns), 64'(m_active));
   endtask

   task automatic do_start(input logic [35:0] i1, input logic [35:0] i2);
      p1ships_init = i1;
      p2ships_init = i2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 36; i++) begin
         m_ship[0][i]  = i1[i];
         m_ship[1][i]  = i2[i];
         m_fired[0][i] = 1'b0;
         m_fired[1][i] = 1'b0;
      end
      m_turn = 0; m_active = 1'b1; m_over = 1'b0; age = 1;
      check_eq("start.ready", 64'(shot_ready), 64'(1'b1));
      check_eq("start.hit", 64'(hit | miss | reject | timeout), 64'(1'b0));
      check_state("start");
   endtask

   // The CHECK cycle has been sampled; the next cycle is a fresh turn or the end of the game.
   task automatic end_turn(input string tag);
      @(negedge clk);
      shot_valid = 1'b0;
      if (afloat(0) == 0 || afloat(1) == 0) begin
         m_active = 1'b0;
         m_over   = 1'b1;
      end else begin
         m_turn = 1 - m_turn;
      end
      age = 1;
      check_eq({tag, ".ready"}, 64'(shot_ready), 64'(m_active));
      check_state(tag);
   endtask

   task automatic do_shot(input int r, input int c, input bit stray);
      int idx, cur, opp;
      bit legal, exp_hit;
      cur   = m_turn;
      opp   = 1 - cur;
      idx   = r * 6 + c;
      legal = (r < 6) && (c < 6);
      if (legal) legal = !m_fired[cur][idx];
      check_eq("shot.ready_pre", 64'(shot_ready), 64'(1'b1));
      shot_valid = 1'b1;
      shot_row   = 3'(r);
      shot_col   = 3'(c);
      @(negedge clk);
      if (!legal) begin
         shot_valid = 1'b0;
         age = 1;
         check_eq("rej.reject", 64'(reject), 64'(1'b1));
         check_eq("rej.hitmiss", 64'({hit, miss, timeout}), 64'(3'b000));
         check_eq("rej.ready", 64'(shot_ready), 64'(1'b1));
         check_state("rej");
      end else begin
         exp_hit = m_ship[opp][idx];
         m_ship[opp][idx] = 1'b0;
         m_fired[cur][idx] = 1'b1;
         shot_valid = stray;
         check_eq("res.hit", 64'(hit), 64'(exp_hit));
         check_eq("res.miss", 64'(miss), 64'(!exp_hit));
         check_eq("res.rej_tmo", 64'({reject, timeout}), 64'(2'b00));
         check_eq("res.ready", 64'(shot_ready), 64'(1'b0));
         check_state("res");
         @(negedge clk);
         check_eq("chk.pulses", 64'({hit, miss, reject, timeout}), 64'(4'b0000));
         check_eq("chk.ready", 64'(shot_ready), 64'(1'b0));
         check_eq("chk.taking", 64'(taking_turns), 64'(1'b1));
         end_turn("next");
      end
   endtask

   task automatic do_idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         age++;
         check_eq("idle.timeout", 64'(timeout), 64'(1'b0));
         check_eq("idle.ready", 64'(shot_ready), 64'(1'b1));
      end
   endtask

   task automatic do_timeout();
      do_idle(T - age);
      @(negedge clk);
      check_eq("tmo.timeout", 64'(timeout), 64'(1'b1));
      check_eq("tmo.ready", 64'(shot_ready), 64'(1'b0));
      check_eq("tmo.hitmiss", 64'({hit, miss, reject}), 64'(3'b000));
      check_state("tmo");
      end_turn("tmo.next");
   endtask

   task automatic poke_start();
      p1ships_init = rand_board();
      p2ships_init = rand_board();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      age++;
      check_eq("poke.ready", 64'(shot_ready), 64'(1'b1));
      check_state("poke");
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, ".flags"}, 64'({shot_ready, taking_turns, turn, game_over}), 64'(4'b0000));
      check_eq({tag, ".pulses"}, 64'({hit, miss, reject, timeout}), 64'(4'b0000));
      check_eq({tag, ".ships"}, 64'({p1ships, p2ships}), 64'(72'd0));
   endtask

   task automatic do_reset_mid();
      #2 reset = 1'b0;
      #1 check_reset_outputs("rst_async");
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 36; i++) begin
         m_ship[0][i] = 1'b0; m_ship[1][i] = 1'b0;
      end
      m_turn = 0; m_active = 1'b0; m_over = 1'b0;
      shot_valid = 1'b1;
      shot_row   = 3'd0;
      shot_col   = 3'd0;
      @(negedge clk);
      shot_valid = 1'b0;
      check_reset_outputs("idle_shot");
      check_state("idle_shot");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sel;
      reset = 1'b0; start = 1'b0; shot_valid = 1'b0;
      shot_row = 3'd0; shot_col = 3'd0;
      p1ships_init = 36'd0; p2ships_init = 36'd0;
      m_turn = 0; m_active = 1'b0; m_over = 1'b0; age = 0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b1;

      do_start(36'h8, 36'h1);
      do_shot(0, 0, 1'b0);
      check_eq("win.game_over", 64'(game_over), 64'(1'b1));

      do_start(36'h3, 36'h30);
      do_shot(5, 5, 1'b1);
      do_shot(5, 5, 1'b0);
      do_shot(6, 0, 1'b0);
      do_shot(2, 3, 1'b0);
      do_shot(0, 0, 1'b0);
      do_shot(2, 3, 1'b0);
      do_idle(3);
      do_timeout();
      poke_start();
      do_shot(2, 3, 1'b1);
      do_shot(0, 7, 1'b0);
      do_reset_mid();

      for (int a = 0; a < 600; a++) begin
         if (!m_active) begin
            do_start(rand_board(), rand_board());
            continue;
         end
         sel = int'($urandom_range(0, 99));
         if (sel < 72) begin
            do_shot(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
         end else if (sel < 82) begin
            do_idle(int'($urandom_range(0, 32'(T - age))));
         end else if (sel < 90) begin
            do_timeout();
         end else if (sel < 97 && age < T) begin
            poke_start();
         end else if (sel >= 98) begin
            do_reset_mid();
         end else begin
            do_shot(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 1'b0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
